// File: rtl/si5338_cfg_ctrl_pkg.sv
// Shared types and constants for the Si5338 I2C register-table sequencer.
package cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_BIT,
    ST_STOP
  } state_e;

  typedef enum logic [2:0] {
    SYM_START,
    SYM_DATA0,
    SYM_DATA1,
    SYM_ACK,
    SYM_STOP
  } sym_e;

  localparam int REG_MSB         = 15;
  localparam int REG_LSB         = 8;
  localparam int VAL_MSB         = 7;
  localparam int VAL_LSB         = 0;
  localparam int SYMBOL_QUARTERS = 4;
  localparam int BITS_PER_XFER   = 27;
  localparam int DIV_W           = 10;

endpackage

// File: rtl/si5338_cfg_ctrl_bit_engine.sv
// Quarter-bit divider and per-symbol open-drain SCL/SDA drive with ACK sampling.
module i2c_bit_engine
  import cfg_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  sym_e i_sym,
  input  logic i_sda,
  output logic o_sym_done,
  output logic o_ack_n,
  output logic o_scl_oe,
  output logic o_sda_oe
);

  logic [DIV_W-1:0] r_cnt;
  logic [1:0]       r_q;
  logic             r_ack_n;
  logic             r_scl_oe;
  logic             r_sda_oe;
  logic             w_qtick;
  logic             w_scl_nxt;
  logic             w_sda_nxt;

  assign w_qtick    = i_run && (r_cnt == DIV_W'(CLK_DIV - 1));
  assign o_sym_done = w_qtick && (r_q == 2'(SYMBOL_QUARTERS - 1));
  assign o_ack_n    = r_ack_n;
  assign o_scl_oe   = r_scl_oe;
  assign o_sda_oe   = r_sda_oe;

  // SCL is low in q0/q1 and released in q2/q3 for data and ACK slots.
  always_comb begin
    w_scl_nxt = 1'b0;
    w_sda_nxt = 1'b0;
    case (i_sym)
      SYM_START: begin
        w_sda_nxt = (r_q != 2'd0);
        w_scl_nxt = r_q[1];
      end
      SYM_DATA0: begin
        w_scl_nxt = ~r_q[1];
        w_sda_nxt = 1'b1;
      end
      SYM_DATA1: w_scl_nxt = ~r_q[1];
      SYM_ACK:   w_scl_nxt = ~r_q[1];
      SYM_STOP: begin
        w_scl_nxt = (r_q == 2'd0);
        w_sda_nxt = ~r_q[1];
      end
      default: ;
    endcase
    if (!i_run) begin
      w_scl_nxt = 1'b0;
      w_sda_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_q      <= '0;
      r_ack_n  <= 1'b1;
      r_scl_oe <= 1'b0;
      r_sda_oe <= 1'b0;
    end else begin
      r_scl_oe <= w_scl_nxt;
      r_sda_oe <= w_sda_nxt;
      if (!i_run) begin
        r_cnt <= '0;
        r_q   <= '0;
      end else begin
        r_cnt <= w_qtick ? '0 : r_cnt + 1'b1;
        if (w_qtick) r_q <= r_q + 2'd1;
        if (w_qtick && (i_sym == SYM_ACK) && (r_q == 2'd2)) r_ack_n <= i_sda;
      end
    end
  end

endmodule

// File: rtl/si5338_cfg_ctrl.sv
// Walks the (reg_addr, value) table and writes each entry to the Si5338 over I2C.
module si5338_cfg_ctrl
  import cfg_pkg::*;
#(
  parameter int         CLK_DIV  = 25,
  parameter logic [6:0] DEV_ADDR = 7'h70,
  parameter int         NUM_REGS = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  output logic [7:0]  tbl_idx_o,
  input  logic [15:0] tbl_data_i,
  output logic        scl_oe_o,
  output logic        sda_oe_o,
  input  logic        sda_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  err_idx_o
);

  localparam int SLOTS_PER_BYTE = BITS_PER_XFER / 3;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_fetch_ph;
  logic [23:0] r_shift;
  logic [3:0]  r_bit;
  logic [1:0]  r_byte;
  logic        r_err_pend;
  logic [7:0]  r_idx;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [7:0]  r_err_idx;
  logic        w_run;
  logic        w_ack_slot;
  logic        w_last;
  logic        w_sym_done;
  logic        w_ack_n;
  sym_e        w_sym;

  assign w_run      = (r_state == ST_START) || (r_state == ST_BIT) || (r_state == ST_STOP);
  assign w_ack_slot = (r_bit == 4'(SLOTS_PER_BYTE - 1));
  assign w_last     = (r_idx == 8'(NUM_REGS - 1));

  assign tbl_idx_o = r_idx;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign err_idx_o = r_err_idx;

  always_comb begin
    w_sym = SYM_START;
    case (r_state)
      ST_BIT:  w_sym = w_ack_slot ? SYM_ACK : (r_shift[23] ? SYM_DATA1 : SYM_DATA0);
      ST_STOP: w_sym = SYM_STOP;
      default: w_sym = SYM_START;
    endcase
  end

  i2c_bit_engine #(.CLK_DIV(CLK_DIV)) u_bit_engine (
    .i_clk      (clk_i),
    .i_rst_n    (rst_n_i),
    .i_run      (w_run),
    .i_sym      (w_sym),
    .i_sda      (sda_i),
    .o_sym_done (w_sym_done),
    .o_ack_n    (w_ack_n),
    .o_scl_oe   (scl_oe_o),
    .o_sda_oe   (sda_oe_o)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start_i) w_state_nxt = ST_FETCH;
      ST_FETCH: if (r_fetch_ph) w_state_nxt = ST_START;
      ST_START: if (w_sym_done) w_state_nxt = ST_BIT;
      ST_BIT:   if (w_sym_done && w_ack_slot && (w_ack_n || (r_byte == 2'd2))) w_state_nxt = ST_STOP;
      ST_STOP:  if (w_sym_done) w_state_nxt = (r_err_pend || w_last) ? ST_IDLE : ST_FETCH;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fetch_ph <= 1'b0;
      r_shift    <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_err_pend <= 1'b0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_idx  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start_i) begin
          r_done     <= 1'b0;
          r_err      <= 1'b0;
          r_err_idx  <= '0;
          r_idx      <= '0;
          r_busy     <= 1'b1;
          r_fetch_ph <= 1'b0;
        end
        // Phase 0 lets the table settle on the new index; phase 1 captures it.
        ST_FETCH: begin
          r_fetch_ph <= ~r_fetch_ph;
          if (r_fetch_ph) begin
            r_shift    <= {DEV_ADDR, 1'b0, tbl_data_i[REG_MSB:REG_LSB], tbl_data_i[VAL_MSB:VAL_LSB]};
            r_bit      <= '0;
            r_byte     <= '0;
            r_err_pend <= 1'b0;
          end
        end
        ST_BIT: if (w_sym_done) begin
          if (w_ack_slot) begin
            if (w_ack_n) r_err_pend <= 1'b1;
            r_bit  <= '0;
            r_byte <= r_byte + 2'd1;
          end else begin
            r_shift <= {r_shift[22:0], 1'b0};
            r_bit   <= r_bit + 4'd1;
          end
        end
        ST_STOP: if (w_sym_done) begin
          if (r_err_pend) begin
            r_err     <= 1'b1;
            r_err_idx <= r_idx;
            r_busy    <= 1'b0;
          end else if (w_last) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end else begin
            r_idx      <= r_idx + 8'd1;
            r_fetch_ph <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
